// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter that owns the select line of a shared 2:1 data mux.
// Grants are held per request, optionally pre-empted under contention, with one dead cycle per handover.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int              HW         = (MAX_HOLD > 32'sd0) ? $clog2(MAX_HOLD + 32'sd1) : 32'sd1;
  localparam bit              PREEMPT_EN = (MAX_HOLD != 32'sd0);
  localparam logic [HW-1:0]   HOLD_MAX   = HW'(MAX_HOLD);
  localparam logic [HW-1:0]   HOLD_ONE   = HW'(1);
  localparam logic [HW-1:0]   HOLD_ZERO  = HW'(0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t          state_r;
  logic            last_r;
  logic [HW-1:0]   hold_cnt_r;
  logic            hold_sat_s;
  logic            preempt0_s;
  logic            preempt1_s;

  // hold_sat_s only ever asserts when pre-emption is enabled
  assign hold_sat_s = PREEMPT_EN && (hold_cnt_r == HOLD_MAX);
  assign preempt0_s = hold_sat_s & req1;
  assign preempt1_s = hold_sat_s & req0;

  assign dout       = sel ? din1 : din0;
  assign dout_valid = (gnt0 & req0) | (gnt1 & req1);

  // Arbitration FSM; every grant change passes through IDLE so handovers leave one dead cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      sel        <= 1'b0;
      busy       <= 1'b0;
      last_r     <= 1'b1;
      hold_cnt_r <= HOLD_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          // on a tie the requester that was not served last wins
          if (req0 && (!req1 || last_r)) begin
            state_r    <= GRANT0;
            gnt0       <= 1'b1;
            gnt1       <= 1'b0;
            sel        <= 1'b0;
            busy       <= 1'b1;
            last_r     <= 1'b0;
            hold_cnt_r <= HOLD_ONE;
          end else if (req1) begin
            state_r    <= GRANT1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b1;
            sel        <= 1'b1;
            busy       <= 1'b1;
            last_r     <= 1'b1;
            hold_cnt_r <= HOLD_ONE;
          end else begin
            state_r    <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            busy       <= 1'b0;
          end
        end
        GRANT0: begin
          if (!req0 || preempt0_s) begin
            state_r    <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            busy       <= 1'b0;
            hold_cnt_r <= HOLD_ZERO;
          end else if (PREEMPT_EN && !hold_sat_s) begin
            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        GRANT1: begin
          if (!req1 || preempt1_s) begin
            state_r    <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            busy       <= 1'b0;
            hold_cnt_r <= HOLD_ZERO;
          end else if (PREEMPT_EN && !hold_sat_s) begin
            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          gnt0       <= 1'b0;
          gnt1       <= 1'b0;
          busy       <= 1'b0;
          hold_cnt_r <= HOLD_ZERO;
        end
      endcase
    end
  end

endmodule
